// File: rtl/mem_copy_engine_pkg.sv
// Shared types and width defaults for the memory copy engine.
// Holds the FSM state enum and the default bus widths.
package mem_copy_engine_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus initiator copying a block of words over the shared data bus.
// Ports: clock/reset_n, start+src_base/dst_base/length command,
// busy/done status, bus_request/bus_grant arbitration, and the
// mem_address/mem_write_data/mem_write_enable/mem_read_data bus.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] src_ptr, src_n;
  logic [ADDR_WIDTH-1:0] dst_ptr, dst_n;
  logic [ADDR_WIDTH-1:0] remaining, rem_n;
  logic [DATA_WIDTH-1:0] data_reg, data_n;

  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_reg  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_n;
      src_ptr   <= src_n;
      dst_ptr   <= dst_n;
      remaining <= rem_n;
      data_reg  <= data_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
    end
  end

  always_comb begin
    state_n = state;
    src_n   = src_ptr;
    dst_n   = dst_ptr;
    rem_n   = remaining;
    data_n  = data_reg;
    unique case (state)
      IDLE: begin
        if (start) begin
          src_n   = src_base;
          dst_n   = dst_base;
          rem_n   = length;
          state_n = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        if (bus_grant) state_n = CAPTURE;
      end
      CAPTURE: begin
        // read was issued under grant last cycle
        data_n  = mem_read_data;
        state_n = WRITE;
      end
      WRITE: begin
        if (bus_grant) begin
          src_n   = src_ptr + ADDR_WIDTH'(1);
          dst_n   = dst_ptr + ADDR_WIDTH'(1);
          rem_n   = remaining - ADDR_WIDTH'(1);
          state_n = (remaining != ADDR_WIDTH'(1)) ? READ : DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the upcoming state so the
  // bus sees clean values for the whole cycle.
  always_comb begin
    busy_n  = (state_n == READ) || (state_n == CAPTURE) ||
              (state_n == WRITE);
    done_n  = (state_n == DONE);
    addr_n  = '0;
    wdata_n = '0;
    if (state_n == READ) begin
      addr_n = src_n;
    end else if (state_n == WRITE) begin
      addr_n  = dst_n;
      wdata_n = data_n;
    end
  end

  assign busy             = busy_q;
  assign bus_request      = busy_q;
  assign done             = done_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = (state == WRITE) && bus_grant;

endmodule
